ps2_host_tx_ctrl: RTL and testbench
===================================

PS2_HOST_TX_CTRL -- requirements
Module: ps2_host_tx_ctrl

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 5000, meaning hclk cycles of PS/2 clock hold-low before request-to-send (100 us at 50 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 1000000, meaning max hclk cycles from clock release to end of transfer.
REQ-003 SHALL have port hclk  input  1  the single clock; all logic on its rising edge.
REQ-004 SHALL have port hresetn  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port cmd_valid_i  input  1  command byte offered.
REQ-006 SHALL have port cmd_data_i  input  8  command byte to send to the keyboard, e.g. 0xED set-LEDs.
REQ-007 SHALL have port cmd_ready_o  output  1  controller accepts a command this cycle.
REQ-008 SHALL have port ps2_clk_i  input  1  raw PS/2 clock line.
REQ-009 SHALL have port ps2_dat_i  input  1  raw PS/2 data line.
REQ-010 SHALL have port ps2_clk_oe_o  output  1  1 = pull clock line low (open-drain).
REQ-011 SHALL have port ps2_dat_oe_o  output  1  1 = pull data line low (open-drain).
REQ-012 SHALL have port rx_inhibit_o  output  1  1 = keyboard receiver must ignore line activity.
REQ-013 SHALL have port busy_o  output  1  transaction in progress.
REQ-014 SHALL have port done_o  output  1  one-cycle pulse: byte sent and ACK received.
REQ-015 SHALL have port err_o  output  1  one-cycle pulse: transaction failed.
REQ-016 SHALL have port err_code_o  output  2  0 none, 1 no ACK, 2 timeout; held until the next accepted command.

Function
REQ-017 SHALL synchronise ps2_clk_i through a 3-flop chain; falling edge = stage2 high and stage1 low; ps2_dat_i sampled on that edge cycle.
REQ-018 SHALL assert cmd_ready_o only in IDLE; handshake completes when cmd_valid_i and cmd_ready_o are both high, latching cmd_data_i and computing odd parity (parity bit = ~^data).
REQ-019 SHALL implement states IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, RELEASE.
REQ-020 IDLE -> INHIBIT on handshake; INHIBIT drives ps2_clk_oe_o=1 for exactly INHIBIT_CYC cycles.
REQ-021 INHIBIT -> RTS: ps2_dat_oe_o=1 (start bit 0) set in the last INHIBIT cycle, ps2_clk_oe_o=0 from RTS entry; timeout counter cleared.
REQ-022 RTS -> DATA on first falling edge; on each falling edge in DATA the next bit is driven LSB first (ps2_dat_oe_o = ~bit); after 8 edges -> PARITY.
REQ-023 PARITY: parity bit driven on next falling edge -> STOP; STOP: ps2_dat_oe_o=0 (stop bit 1) on next falling edge -> ACK.
REQ-024 ACK: on next falling edge sample data; 0 -> RELEASE, 1 -> no-ACK error.
REQ-025 RELEASE: wait for synchronised clock and data both high, then done_o pulse, -> IDLE.
REQ-026 Timeout counter SHALL run in RTS..RELEASE; reaching TIMEOUT_CYC-1 -> timeout error regardless of state.
REQ-027 On error: both oe outputs 0 same cycle, err_o pulse, err_code_o set, -> IDLE; timeout takes priority over no-ACK in the same cycle.
REQ-028 busy_o and rx_inhibit_o SHALL be 1 in every state except IDLE.
REQ-029 cmd_valid_i while busy SHALL be ignored (not queued); done_o and err_o never assert together.

Reset
REQ-030 Low hresetn at a clock edge SHALL force IDLE, oe outputs 0, cmd_ready_o 1 after release, busy_o/rx_inhibit_o/done_o/err_o 0, err_code_o 0, counters 0, sync flops 1.
REQ-031 Reset mid-transaction SHALL release both lines in the cycle following the reset edge and discard the command without done_o or err_o.

Configuration
REQ-032 Macro PS2_TX_RETRY_EN defined: on no-ACK or timeout, re-enter INHIBIT with the same byte up to 2 times; err_o only after the third failure; busy_o held throughout.
REQ-033 Macro PS2_TX_RETRY_EN undefined: first failure reports err_o immediately; no retry counter present.

Verification
REQ-034 Send 0xED, device model clocks 11 edges with ACK=0 -> bits 1,0,1,1,0,1,1,1, parity 1 on data line; done_o one pulse; err_code_o 0.
REQ-035 Send 0x00 -> parity bit 1; send 0x01 -> parity bit 0.
REQ-036 Device drives ACK=1 -> err_o pulse, err_code_o 1 (retry off); with PS2_TX_RETRY_EN, three inhibit phases then err_o.
REQ-037 Device never clocks, TIMEOUT_CYC=200 -> err_code_o 2 exactly 200 cycles after RTS entry; lines released.
REQ-038 cmd_valid_i held high with 0x55 during an active 0xF4 transfer -> only 0xF4 sent; 0x55 accepted the cycle after return to IDLE.
REQ-039 hresetn low during DATA bit 4 -> both oe outputs 0 the next cycle, busy_o 0, no done_o/err_o.

Source files
------------

// File: rtl/ps2_host_tx_ctrl.sv
// ps2_host_tx_ctrl
// Host-to-device PS/2 transmitter. Accepts one command byte over a
// valid/ready handshake, inhibits the bus, issues request-to-send, then
// shifts start/data/parity/stop on device clock falling edges and checks
// the device ACK.
//
// Parameters:
//   INHIBIT_CYC  hclk cycles the PS/2 clock is held low before request-to-send
//   TIMEOUT_CYC  max hclk cycles from clock release to end of transfer
//
// Ports:
//   hclk, hresetn             clock, synchronous active-low reset
//   cmd_valid_i, cmd_data_i   command byte offered
//   cmd_ready_o               command accepted this cycle (IDLE only)
//   ps2_clk_i, ps2_dat_i      raw PS/2 lines
//   ps2_clk_oe_o, ps2_dat_oe_o  1 = pull line low (open-drain)
//   rx_inhibit_o, busy_o      high whenever a transaction is in progress
//   done_o, err_o             one-cycle completion / failure pulses
//   err_code_o                0 none, 1 no ACK, 2 timeout; held until next command
//
// Build option:
//   PS2_TX_RETRY_EN  when defined, a failed transfer is retried with the same
//                    byte up to two more times before err_o is reported.
module ps2_host_tx_ctrl #(
    parameter int unsigned INHIBIT_CYC = 5000,
    parameter int unsigned TIMEOUT_CYC = 1000000
) (
    input  logic       hclk,
    input  logic       hresetn,
    input  logic       cmd_valid_i,
    input  logic [7:0] cmd_data_i,
    output logic       cmd_ready_o,
    input  logic       ps2_clk_i,
    input  logic       ps2_dat_i,
    output logic       ps2_clk_oe_o,
    output logic       ps2_dat_oe_o,
    output logic       rx_inhibit_o,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    output logic [1:0] err_code_o
);

    localparam int unsigned CNT_MAX = (INHIBIT_CYC > TIMEOUT_CYC) ? INHIBIT_CYC : TIMEOUT_CYC;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);

    localparam logic [1:0] ERR_NONE  = 2'd0;
    localparam logic [1:0] ERR_NOACK = 2'd1;
    localparam logic [1:0] ERR_TMO   = 2'd2;

    typedef enum logic [2:0] {
        IDLE, INHIBIT, RTS, DATA, PARITY, STOP, ACK, RELEASE
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       data_q, data_d;
    logic             par_q, par_d;
    logic             dat_oe_q, dat_oe_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             fail;
    logic [1:0]       fail_code;
    logic             in_xfer;

    logic [2:0]       clk_sync;
    logic [1:0]       dat_sync;
    logic             clk_fall;

`ifdef PS2_TX_RETRY_EN
    logic [1:0]       retry_q, retry_d;
`endif

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            clk_sync <= '1;
            dat_sync <= '1;
        end else begin
            clk_sync <= {clk_sync[1:0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
        end
    end

    // Data uses one stage fewer so the sampled bit is aligned with the
    // clock sample pair that reveals the falling edge.
    assign clk_fall = clk_sync[2] & ~clk_sync[1];
    assign in_xfer  = (state_q != IDLE) && (state_q != INHIBIT);

    always_ff @(posedge hclk) begin
        if (!hresetn) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_q      <= 1'b0;
            dat_oe_q   <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_q      <= par_d;
            dat_oe_q   <= dat_oe_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
`ifdef PS2_TX_RETRY_EN
            retry_q    <= retry_d;
`endif
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_d      = par_q;
        dat_oe_d   = dat_oe_q;
        err_code_d = err_code_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        fail       = 1'b0;
        fail_code  = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
        retry_d    = retry_q;
`endif

        // One counter serves both the inhibit hold and the transfer timeout.
        if (in_xfer) begin
            cnt_d = cnt_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (cmd_valid_i) begin
                    state_d    = INHIBIT;
                    cnt_d      = '0;
                    bit_idx_d  = '0;
                    data_d     = cmd_data_i;
                    par_d      = ~^cmd_data_i;
                    err_code_d = ERR_NONE;
`ifdef PS2_TX_RETRY_EN
                    retry_d    = '0;
`endif
                end
            end
            INHIBIT: begin
                if (cnt_q == INH_LAST) begin
                    state_d  = RTS;
                    cnt_d    = '0;
                    dat_oe_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RTS: begin
                if (clk_fall) begin
                    dat_oe_d  = ~data_q[0];
                    bit_idx_d = 3'd1;
                    state_d   = DATA;
                end
            end
            DATA: begin
                if (clk_fall) begin
                    dat_oe_d = ~data_q[bit_idx_q];
                    if (bit_idx_q == 3'd7) begin
                        state_d = PARITY;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (clk_fall) begin
                    dat_oe_d = ~par_q;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (clk_fall) begin
                    dat_oe_d = 1'b0;
                    state_d  = ACK;
                end
            end
            ACK: begin
                if (clk_fall) begin
                    if (dat_sync[1]) begin
                        fail      = 1'b1;
                        fail_code = ERR_NOACK;
                    end else begin
                        state_d = RELEASE;
                    end
                end
            end
            RELEASE: begin
                if (clk_sync[2] && dat_sync[1]) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        // Evaluated after the ACK check so a coincident timeout wins.
        if (in_xfer && (cnt_q == TMO_LAST)) begin
            fail      = 1'b1;
            fail_code = ERR_TMO;
        end

        if (fail) begin
            dat_oe_d  = 1'b0;
            cnt_d     = '0;
            bit_idx_d = '0;
            done_d    = 1'b0;
`ifdef PS2_TX_RETRY_EN
            if (retry_q != 2'd2) begin
                retry_d = retry_q + 2'd1;
                state_d = INHIBIT;
            end else begin
                state_d    = IDLE;
                err_d      = 1'b1;
                err_code_d = fail_code;
            end
`else
            state_d    = IDLE;
            err_d      = 1'b1;
            err_code_d = fail_code;
`endif
        end
    end

    assign cmd_ready_o  = (state_q == IDLE);
    assign busy_o       = (state_q != IDLE);
    assign rx_inhibit_o = (state_q != IDLE);
    assign ps2_clk_oe_o = (state_q == INHIBIT);
    // Start bit goes out during the final inhibit cycle, ahead of the clock release.
    assign ps2_dat_oe_o = dat_oe_q | ((state_q == INHIBIT) && (cnt_q == INH_LAST));
    assign done_o       = done_q;
    assign err_o        = err_q;
    assign err_code_o   = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx_ctrl.sv
module tb_ps2_host_tx_ctrl;

    localparam int INH  = 20;
    localparam int TMO  = 200;
    localparam int HALF = 6;
`ifdef PS2_TX_RETRY_EN
    localparam int NTRY = 3;
`else
    localparam int NTRY = 1;
`endif

    logic       hclk = 1'b0;
    logic       hresetn = 1'b0;
    logic       cmd_valid = 1'b0;
    logic [7:0] cmd_data = '0;
    logic       cmd_ready, clk_oe, dat_oe, rx_inhibit, busy, done, err;
    logic [1:0] err_code;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    logic       ps2_clk, ps2_dat;

    // Open-drain bus: either side can pull a line low.
    assign ps2_clk = dev_clk & ~clk_oe;
    assign ps2_dat = dev_dat & ~dat_oe;

    always #5 hclk = ~hclk;

    ps2_host_tx_ctrl #(
        .INHIBIT_CYC(INH),
        .TIMEOUT_CYC(TMO)
    ) dut (
        .hclk        (hclk),
        .hresetn     (hresetn),
        .cmd_valid_i (cmd_valid),
        .cmd_data_i  (cmd_data),
        .cmd_ready_o (cmd_ready),
        .ps2_clk_i   (ps2_clk),
        .ps2_dat_i   (ps2_dat),
        .ps2_clk_oe_o(clk_oe),
        .ps2_dat_oe_o(dat_oe),
        .rx_inhibit_o(rx_inhibit),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .err_code_o  (err_code)
    );

    int checks = 0;
    int passes = 0;

    int   done_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   inh_rise = 0;
    logic clk_oe_prev = 1'b0;

    always @(negedge hclk) begin
        if (done === 1'b1) done_cnt++;
        if (err === 1'b1) err_cnt++;
        if (done === 1'b1 && err === 1'b1) both_cnt++;
        if (clk_oe === 1'b1 && clk_oe_prev !== 1'b1) inh_rise++;
        clk_oe_prev = clk_oe;
    end

    typedef struct packed {
        logic [7:0] data;
        logic       par;
    } frame_t;
    frame_t sb_q[$];

    function automatic logic odd_par(input logic [7:0] b);
        int ones = 0;
        for (int i = 0; i < 8; i++) if (b[i]) ones++;
        return ((ones % 2) == 0) ? 1'b1 : 1'b0;
    endfunction

    // Results captured by the device model.
    logic       dx_ok, dx_start, dx_par, dx_stop, dx_first, dx_last;
    logic [7:0] dx_data;
    int         dx_inh;

    task automatic send_cmd(input logic [7:0] b);
        int n = 0;
        @(negedge hclk);
        cmd_valid = 1'b1;
        cmd_data  = b;
        while (cmd_ready !== 1'b1 && n < 100) begin @(negedge hclk); n++; end
        checks++;
        if (cmd_ready !== 1'b1) $display("FAIL handshake: cmd_ready=%b required 1", cmd_ready);
        else passes++;
        @(negedge hclk);
        cmd_valid = 1'b0;
    endtask

    // Device side: observe inhibit/RTS, then generate npulses clock pulses,
    // sampling the data line just before each rising edge.
    task automatic dev_xfer(input logic ack, input int npulses);
        int n = 0;
        dx_ok = 1'b1; dx_data = '0; dx_par = 1'b0; dx_stop = 1'b0;
        dx_inh = 0; dx_first = 1'b0; dx_last = 1'b0; dx_start = 1'b0;
        while (clk_oe !== 1'b1 && n < 2000) begin @(negedge hclk); n++; end
        if (clk_oe !== 1'b1) begin dx_ok = 1'b0; return; end
        dx_first = dat_oe;
        while (clk_oe === 1'b1 && dx_inh < 2000) begin
            dx_last = dat_oe;
            dx_inh++;
            @(negedge hclk);
        end
        dx_start = ~ps2_dat;
        if (npulses > 0) repeat (2) @(negedge hclk);
        for (int k = 0; k < npulses; k++) begin
            dev_clk = 1'b0;
            repeat (HALF) @(negedge hclk);
            if (k < 8) dx_data[k] = ps2_dat;
            else if (k == 8) dx_par = ps2_dat;
            else if (k == 9) dx_stop = ps2_dat;
            dev_clk = 1'b1;
            if (k == 9) dev_dat = ack;
            if (k == 10) dev_dat = 1'b1;
            if (k != npulses - 1) repeat (HALF) @(negedge hclk);
        end
    endtask

    task automatic wait_result(input int d0, input int e0);
        int n = 0;
        while (done_cnt == d0 && err_cnt == e0 && n < 300) begin @(negedge hclk); n++; end
        repeat (3) @(negedge hclk);
    endtask

    task automatic test_reset();
        hresetn = 1'b0;
        repeat (3) @(negedge hclk);
        checks++; if (clk_oe !== 1'b0) $display("FAIL rst_clk_oe: got %b required 0", clk_oe); else passes++;
        checks++; if (dat_oe !== 1'b0) $display("FAIL rst_dat_oe: got %b required 0", dat_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL rst_busy: got %b required 0", busy); else passes++;
        checks++; if (rx_inhibit !== 1'b0) $display("FAIL rst_rx_inhibit: got %b required 0", rx_inhibit); else passes++;
        checks++; if (done !== 1'b0 || err !== 1'b0) $display("FAIL rst_pulses: done=%b err=%b required 0 0", done, err); else passes++;
        checks++; if (err_code !== 2'd0) $display("FAIL rst_err_code: got %0d required 0", err_code); else passes++;
        hresetn = 1'b1;
        @(negedge hclk);
        checks++; if (cmd_ready !== 1'b1) $display("FAIL rst_ready: got %b required 1", cmd_ready); else passes++;
    endtask

    task automatic test_send();
        logic [7:0] bytes [6];
        frame_t exp;
        int d0, e0;
        bytes[0] = 8'hED; bytes[1] = 8'h00; bytes[2] = 8'h01;
        for (int i = 3; i < 6; i++) bytes[i] = 8'($urandom_range(0, 255));
        for (int i = 0; i < 6; i++) begin
            exp.data = bytes[i];
            exp.par  = odd_par(bytes[i]);
            sb_q.push_back(exp);
            d0 = done_cnt; e0 = err_cnt;
            send_cmd(bytes[i]);
            dev_xfer(1'b0, 11);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            checks++; if (dx_ok !== 1'b1) $display("FAIL send_inhibit_seen[%0d]: got %b required 1", i, dx_ok); else passes++;
            checks++; if (dx_inh != INH) $display("FAIL send_inhibit_len[%0d]: got %0d required %0d", i, dx_inh, INH); else passes++;
            checks++; if (dx_first !== 1'b0 || dx_last !== 1'b1) $display("FAIL send_start_timing[%0d]: first=%b last=%b required 0 1", i, dx_first, dx_last); else passes++;
            checks++; if (dx_start !== 1'b1) $display("FAIL send_start_bit[%0d]: low=%b required 1", i, dx_start); else passes++;
            checks++; if (dx_data !== exp.data) $display("FAIL send_data[%0d]: got %h required %h", i, dx_data, exp.data); else passes++;
            checks++; if (dx_par !== exp.par) $display("FAIL send_parity[%0d]: got %b required %b", i, dx_par, exp.par); else passes++;
            checks++; if (dx_stop !== 1'b1) $display("FAIL send_stop[%0d]: got %b required 1", i, dx_stop); else passes++;
            wait_result(d0, e0);
            checks++; if (done_cnt - d0 != 1) $display("FAIL send_done[%0d]: got %0d pulses required 1", i, done_cnt - d0); else passes++;
            checks++; if (err_cnt != e0) $display("FAIL send_err[%0d]: got %0d pulses required 0", i, err_cnt - e0); else passes++;
            checks++; if (err_code !== 2'd0) $display("FAIL send_code[%0d]: got %0d required 0", i, err_code); else passes++;
            checks++; if (busy !== 1'b0) $display("FAIL send_idle[%0d]: busy=%b required 0", i, busy); else passes++;
        end
    endtask

    task automatic test_noack();
        frame_t exp;
        int d0 = done_cnt;
        int e0 = err_cnt;
        int i0 = inh_rise;
        for (int t = 0; t < NTRY; t++) begin
            exp.data = 8'hA5; exp.par = odd_par(8'hA5);
            sb_q.push_back(exp);
        end
        send_cmd(8'hA5);
        for (int t = 0; t < NTRY; t++) begin
            dev_xfer(1'b1, 11);
            exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
            checks++; if (dx_data !== exp.data) $display("FAIL noack_data[%0d]: got %h required %h", t, dx_data, exp.data); else passes++;
            if (t < NTRY - 1) begin
                checks++; if (busy !== 1'b1) $display("FAIL noack_busy_held[%0d]: got %b required 1", t, busy); else passes++;
            end
        end
        wait_result(d0, e0);
        checks++; if (err_cnt - e0 != 1) $display("FAIL noack_err: got %0d pulses required 1", err_cnt - e0); else passes++;
        checks++; if (done_cnt != d0) $display("FAIL noack_done: got %0d pulses required 0", done_cnt - d0); else passes++;
        checks++; if (err_code !== 2'd1) $display("FAIL noack_code: got %0d required 1", err_code); else passes++;
        checks++; if (inh_rise - i0 != NTRY) $display("FAIL noack_inhibits: got %0d required %0d", inh_rise - i0, NTRY); else passes++;
    endtask

    task automatic test_timeout();
        int c = 0;
        int d0 = done_cnt;
        send_cmd(8'h42);
        for (int t = 0; t < NTRY; t++) dev_xfer(1'b1, 0);
        // dev_xfer returns on the cycle the clock is released (RTS entry).
        while (err !== 1'b1 && c < 400) begin @(negedge hclk); c++; end
        checks++; if (c != TMO) $display("FAIL timeout_latency: got %0d cycles required %0d", c, TMO); else passes++;
        checks++; if (err_code !== 2'd2) $display("FAIL timeout_code: got %0d required 2", err_code); else passes++;
        checks++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) $display("FAIL timeout_release: clk_oe=%b dat_oe=%b required 0 0", clk_oe, dat_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL timeout_busy: got %b required 0", busy); else passes++;
        repeat (3) @(negedge hclk);
        checks++; if (done_cnt != d0) $display("FAIL timeout_done: got %0d pulses required 0", done_cnt - d0); else passes++;
    endtask

    task automatic test_back_to_back();
        frame_t exp;
        int n = 0;
        int d0 = done_cnt;
        exp.data = 8'hF4; exp.par = odd_par(8'hF4); sb_q.push_back(exp);
        exp.data = 8'h55; exp.par = odd_par(8'h55); sb_q.push_back(exp);
        @(negedge hclk);
        cmd_valid = 1'b1;
        cmd_data  = 8'hF4;
        @(negedge hclk);
        cmd_data  = 8'h55;
        dev_xfer(1'b0, 11);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        checks++; if (dx_data !== exp.data) $display("FAIL b2b_first_data: got %h required %h", dx_data, exp.data); else passes++;
        while (done !== 1'b1 && n < 50) begin @(negedge hclk); n++; end
        checks++; if (done !== 1'b1) $display("FAIL b2b_first_done: got %b required 1", done); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL b2b_ready: got %b required 1", cmd_ready); else passes++;
        @(negedge hclk);
        checks++; if (busy !== 1'b1) $display("FAIL b2b_accept: busy=%b required 1", busy); else passes++;
        cmd_valid = 1'b0;
        dev_xfer(1'b0, 11);
        exp = (sb_q.size() > 0) ? sb_q.pop_front() : '0;
        checks++; if (dx_data !== exp.data) $display("FAIL b2b_second_data: got %h required %h", dx_data, exp.data); else passes++;
        checks++; if (dx_par !== exp.par) $display("FAIL b2b_second_parity: got %b required %b", dx_par, exp.par); else passes++;
        wait_result(done_cnt, err_cnt);
        repeat (20) @(negedge hclk);
        checks++; if (done_cnt - d0 != 2) $display("FAIL b2b_done_count: got %0d required 2", done_cnt - d0); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL b2b_no_third: busy=%b required 0", busy); else passes++;
    endtask

    task automatic test_reset_mid();
        int d0, e0;
        send_cmd(8'h3C);
        dev_xfer(1'b0, 5);
        d0 = done_cnt; e0 = err_cnt;
        @(negedge hclk);
        hresetn = 1'b0;
        @(negedge hclk);
        checks++; if (clk_oe !== 1'b0 || dat_oe !== 1'b0) $display("FAIL midrst_release: clk_oe=%b dat_oe=%b required 0 0", clk_oe, dat_oe); else passes++;
        checks++; if (busy !== 1'b0) $display("FAIL midrst_busy: got %b required 0", busy); else passes++;
        hresetn = 1'b1;
        dev_clk  = 1'b1;
        dev_dat  = 1'b1;
        repeat (30) @(negedge hclk);
        checks++; if (done_cnt != d0 || err_cnt != e0) $display("FAIL midrst_pulses: done=%0d err=%0d required 0 0", done_cnt - d0, err_cnt - e0); else passes++;
        checks++; if (cmd_ready !== 1'b1) $display("FAIL midrst_ready: got %b required 1", cmd_ready); else passes++;
    endtask

    initial begin
        test_reset();
        test_send();
        test_noack();
        test_timeout();
        test_back_to_back();
        test_reset_mid();
        checks++; if (both_cnt != 0) $display("FAIL done_err_overlap: got %0d cycles required 0", both_cnt); else passes++;
        checks++; if (sb_q.size() != 0) $display("FAIL scoreboard_drain: got %0d left required 0", sb_q.size()); else passes++;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, checks passed %0d of %0d", passes, checks);
        $fatal(1, "watchdog");
    end

endmodule
